// File: rtl/sram_client_arbiter_pkg.sv
// Shared constants for the SRAM client arbiter: default word width, read latency,
// arbiter state encodings and the round-robin pointer advance helper.
package sram_client_arbiter_pkg;

    localparam int unsigned SRAM_WORD     = 256;
    localparam int unsigned SRAM_READ_LAT = 3;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_RD_WAIT = 2'd1;
    localparam logic [1:0] ARB_RD_RET  = 2'd2;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sram_client_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping,
// reported both one-hot and as an index.
module sram_client_arbiter_rr_arbiter #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    input  logic          i_en,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx
);

    logic          w_found;
    int unsigned   w_pos;
    logic [IW-1:0] w_sel;

    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        w_sel     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pos = 32'(i_ptr) + i;
            if (w_pos >= N) begin
                w_pos = w_pos - N;
            end
            w_sel = IW'(w_pos);
            if (i_en && !w_found && i_req[w_sel]) begin
                o_gnt[w_sel] = 1'b1;
                o_gnt_idx    = w_sel;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_client_arbiter.sv
// Shares the SRAM controller request/send port between NUM_CLIENT clients: round-robin
// writes (priority) and reads, fixed-latency read return routing, busy-abort of reads.
module sram_client_arbiter
    import sram_client_arbiter_pkg::*;
#(
    parameter int unsigned NUM_CLIENT = 2,
    parameter int unsigned READ_LAT   = SRAM_READ_LAT,
    parameter int unsigned WORD       = SRAM_WORD
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CLIENT-1:0]      i_rd_req,
    output logic [NUM_CLIENT-1:0]      o_rd_ack,
    output logic [NUM_CLIENT-1:0]      o_rd_valid,
    output logic [NUM_CLIENT-1:0]      o_rd_drop,
    output logic [WORD-1:0]            o_rd_data,
    input  logic [NUM_CLIENT-1:0]      i_wr_req,
    input  logic [NUM_CLIENT*WORD-1:0] i_wr_data,
    output logic [NUM_CLIENT-1:0]      o_wr_ack,
    output logic                       o_PE_request,
    input  logic [WORD-1:0]            i_request_data,
    output logic                       o_PE_send,
    output logic [WORD-1:0]            o_send_data,
    input  logic                       i_busy
);

    localparam int unsigned IW = $clog2(NUM_CLIENT);
    localparam int unsigned CW = (READ_LAT > 1) ? $clog2(READ_LAT + 1) : 1;

    logic [1:0]            r_state, w_state_nxt;
    logic [IW-1:0]         r_wp, w_wp_nxt;
    logic [IW-1:0]         r_rp, w_rp_nxt;
    logic [IW-1:0]         r_owner, w_owner_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic                  r_pe_request, w_pe_request_nxt;
    logic                  r_pe_send, w_pe_send_nxt;
    logic [WORD-1:0]       r_send_data, w_send_data_nxt;
    logic [NUM_CLIENT-1:0] r_rd_valid, w_rd_valid_nxt;
    logic [NUM_CLIENT-1:0] r_rd_drop, w_rd_drop_nxt;
    logic [WORD-1:0]       r_rd_data, w_rd_data_nxt;

    logic                  w_grant_ok;
    logic [NUM_CLIENT-1:0] w_wr_gnt, w_rd_gnt;
    logic [IW-1:0]         w_wr_idx, w_rd_idx;
    logic [NUM_CLIENT-1:0] w_owner_oh;
    logic [WORD-1:0]       w_wr_sel_data;

    // Grants only from IDLE with the controller free; RD_WAIT/RD_RET reserve the port.
    assign w_grant_ok = (r_state == ARB_IDLE) && !i_busy;

    sram_client_arbiter_rr_arbiter #(
        .N  (NUM_CLIENT),
        .IW (IW)
    ) u_wr_arb (
        .i_req     (i_wr_req),
        .i_ptr     (r_wp),
        .i_en      (w_grant_ok),
        .o_gnt     (w_wr_gnt),
        .o_gnt_idx (w_wr_idx)
    );

    sram_client_arbiter_rr_arbiter #(
        .N  (NUM_CLIENT),
        .IW (IW)
    ) u_rd_arb (
        .i_req     (i_rd_req),
        .i_ptr     (r_rp),
        .i_en      (w_grant_ok && !(|i_wr_req)),
        .o_gnt     (w_rd_gnt),
        .o_gnt_idx (w_rd_idx)
    );

    assign o_wr_ack   = w_wr_gnt;
    assign o_rd_ack   = w_rd_gnt;
    assign w_owner_oh = NUM_CLIENT'(1) << r_owner;

    always_comb begin
        w_wr_sel_data = '0;
        for (int k = 0; k < int'(NUM_CLIENT); k++) begin
            if (w_wr_gnt[k]) begin
                w_wr_sel_data = i_wr_data[k*WORD +: WORD];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_wp_nxt         = r_wp;
        w_rp_nxt         = r_rp;
        w_owner_nxt      = r_owner;
        w_cnt_nxt        = r_cnt;
        w_pe_request_nxt = 1'b0;
        w_pe_send_nxt    = 1'b0;
        w_send_data_nxt  = r_send_data;
        w_rd_valid_nxt   = '0;
        w_rd_drop_nxt    = '0;
        w_rd_data_nxt    = '0;
        case (r_state)
            ARB_IDLE: begin
                if (|w_wr_gnt) begin
                    w_pe_send_nxt   = 1'b1;
                    w_send_data_nxt = w_wr_sel_data;
                    w_wp_nxt        = IW'(rr_next(32'(w_wr_idx), NUM_CLIENT));
                end else if (|w_rd_gnt) begin
                    w_pe_request_nxt = 1'b1;
                    w_owner_nxt      = w_rd_idx;
                    w_rp_nxt         = IW'(rr_next(32'(w_rd_idx), NUM_CLIENT));
                    w_cnt_nxt        = CW'(READ_LAT);
                    w_state_nxt      = ARB_RD_WAIT;
                end
            end
            ARB_RD_WAIT: begin
                // Busy means T load/init took the controller; the read is lost.
                if (i_busy) begin
                    w_rd_drop_nxt = w_owner_oh;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ARB_IDLE;
                end else if (r_cnt == '0) begin
                    w_rd_data_nxt  = i_request_data;
                    w_rd_valid_nxt = w_owner_oh;
                    w_state_nxt    = ARB_RD_RET;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            ARB_RD_RET: begin
                w_state_nxt = ARB_IDLE;
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARB_IDLE;
            r_wp         <= '0;
            r_rp         <= '0;
            r_owner      <= '0;
            r_cnt        <= '0;
            r_pe_request <= 1'b0;
            r_pe_send    <= 1'b0;
            r_send_data  <= '0;
            r_rd_valid   <= '0;
            r_rd_drop    <= '0;
            r_rd_data    <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_wp         <= w_wp_nxt;
            r_rp         <= w_rp_nxt;
            r_owner      <= w_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pe_request <= w_pe_request_nxt;
            r_pe_send    <= w_pe_send_nxt;
            r_send_data  <= w_send_data_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_rd_drop    <= w_rd_drop_nxt;
            r_rd_data    <= w_rd_data_nxt;
        end
    end

    assign o_PE_request = r_pe_request;
    assign o_PE_send    = r_pe_send;
    assign o_send_data  = r_send_data;
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_drop    = r_rd_drop;
    assign o_rd_data    = r_rd_data;

endmodule

// File: tb/tb_sram_client_arbiter.sv
// Directed bench for sram_client_arbiter: per-cycle vector table plus hand-written
// reset-during-read and read-contention sequences.
module tb_sram_client_arbiter;

    localparam int unsigned NC = 2;
    localparam int unsigned W  = 256;
    localparam logic [15:0] D  = 16'hDEAD;
    localparam logic [1:0]  NS = 2'd2;

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        busy;
        logic [15:0] rqd;
        logic [1:0]  e_rack;
        logic [1:0]  e_wack;
        logic        e_preq;
        logic        e_psend;
        logic [1:0]  e_scli;
        logic [1:0]  e_rval;
        logic [1:0]  e_rdrop;
        logic [15:0] e_rdata;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic [NC-1:0]   i_rd_req;
    logic [NC-1:0]   o_rd_ack;
    logic [NC-1:0]   o_rd_valid;
    logic [NC-1:0]   o_rd_drop;
    logic [W-1:0]    o_rd_data;
    logic [NC-1:0]   i_wr_req;
    logic [NC*W-1:0] i_wr_data;
    logic [NC-1:0]   o_wr_ack;
    logic            o_PE_request;
    logic [W-1:0]    i_request_data;
    logic            o_PE_send;
    logic [W-1:0]    o_send_data;
    logic            i_busy;

    logic [W-1:0] wd0, wd1;
    vec_t         vecs[$];
    int           n_cmp;
    int           n_err;

    sram_client_arbiter #(
        .NUM_CLIENT (NC),
        .READ_LAT   (3),
        .WORD       (W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rd_req       (i_rd_req),
        .o_rd_ack       (o_rd_ack),
        .o_rd_valid     (o_rd_valid),
        .o_rd_drop      (o_rd_drop),
        .o_rd_data      (o_rd_data),
        .i_wr_req       (i_wr_req),
        .i_wr_data      (i_wr_data),
        .o_wr_ack       (o_wr_ack),
        .o_PE_request   (o_PE_request),
        .i_request_data (i_request_data),
        .o_PE_send      (o_PE_send),
        .o_send_data    (o_send_data),
        .i_busy         (i_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] rd, input logic [1:0] wr, input logic busy,
                       input logic [15:0] rqd, input logic [1:0] rack, input logic [1:0] wack,
                       input logic preq, input logic psend, input logic [1:0] scli,
                       input logic [1:0] rval, input logic [1:0] rdrop,
                       input logic [15:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.busy = busy; v.rqd = rqd;
        v.e_rack = rack; v.e_wack = wack; v.e_preq = preq; v.e_psend = psend;
        v.e_scli = scli; v.e_rval = rval; v.e_rdrop = rdrop; v.e_rdata = rdata;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic step(input logic [1:0] rd, input logic [1:0] wr, input logic busy,
                        input logic [15:0] rqd);
        @(negedge clk);
        i_rd_req       = rd;
        i_wr_req       = wr;
        i_busy         = busy;
        i_request_data = W'(rqd);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_ack"},    W'(o_rd_ack),     '0);
        chk({tag, " wr_ack"},    W'(o_wr_ack),     '0);
        chk({tag, " rd_valid"},  W'(o_rd_valid),   '0);
        chk({tag, " rd_drop"},   W'(o_rd_drop),    '0);
        chk({tag, " rd_data"},   o_rd_data,        '0);
        chk({tag, " PE_request"}, W'(o_PE_request), '0);
        chk({tag, " PE_send"},   W'(o_PE_send),    '0);
        chk({tag, " send_data"}, o_send_data,      '0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        wd0 = {32{8'h3C}};
        wd1 = {32{8'hA5}};
        i_wr_data = {wd1, wd0};
        rst_n = 1'b0;
        i_rd_req = '0;
        i_wr_req = '0;
        i_busy = 1'b0;
        i_request_data = W'(D);

        //  rd     wr     b     rqd       rack   wack   pq    ps    scli   rval   drop   rdata
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);   // 0
        add(2'b00, 2'b10, 1'b0, D,        2'b00, 2'b10, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);   // 1 write c1
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b1, 2'd1,  2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b11, 1'b0, D,        2'b00, 2'b01, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);   // 4 wp=0
        add(2'b00, 2'b10, 1'b0, D,        2'b00, 2'b10, 1'b0, 1'b1, 2'd0,  2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b1, 2'd1,  2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b01, 2'b00, 1'b0, D,        2'b01, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);   // 8 read c0
        add(2'b10, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b1, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b10, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b10, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b10, 2'b00, 1'b0, 16'h1234, 2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b10, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b01, 2'b00, 16'h1234);
        add(2'b10, 2'b00, 1'b0, D,        2'b10, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);   // 14
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b1, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, 16'h5678, 2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b10, 2'b00, 16'h5678);
        add(2'b01, 2'b10, 1'b0, D,        2'b00, 2'b10, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);   // 20 priority
        add(2'b01, 2'b00, 1'b0, D,        2'b01, 2'b00, 1'b0, 1'b1, 2'd1,  2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b1, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, 16'h9ABC, 2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b01, 2'b00, 16'h9ABC);
        add(2'b10, 2'b00, 1'b0, D,        2'b10, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);   // 27 abort
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b1, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b00, 2'b00, 1'b1, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b01, 2'b00, 1'b1, D,        2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b10, 16'h0);
        add(2'b01, 2'b01, 1'b1, 16'h1111, 2'b00, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);
        add(2'b01, 2'b00, 1'b0, D,        2'b01, 2'b00, 1'b0, 1'b0, NS,    2'b00, 2'b00, 16'h0);   // 32
        add(2'b00, 2'b00, 1'b0, D,        2'b00, 2'b00, 1'b1, 1'b0, NS,    2'b00, 2'b00, 16'h0);

        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].rd, vecs[i].wr, vecs[i].busy, vecs[i].rqd);
            chk($sformatf("v%0d rd_ack", i),     W'(o_rd_ack),     W'(vecs[i].e_rack));
            chk($sformatf("v%0d wr_ack", i),     W'(o_wr_ack),     W'(vecs[i].e_wack));
            chk($sformatf("v%0d PE_request", i), W'(o_PE_request), W'(vecs[i].e_preq));
            chk($sformatf("v%0d PE_send", i),    W'(o_PE_send),    W'(vecs[i].e_psend));
            chk($sformatf("v%0d rd_valid", i),   W'(o_rd_valid),   W'(vecs[i].e_rval));
            chk($sformatf("v%0d rd_drop", i),    W'(o_rd_drop),    W'(vecs[i].e_rdrop));
            chk($sformatf("v%0d rd_data", i),    o_rd_data,        W'(vecs[i].e_rdata));
            if (vecs[i].e_scli != NS) begin
                chk($sformatf("v%0d send_data", i), o_send_data,
                    (vecs[i].e_scli == 2'd1) ? wd1 : wd0);
            end
        end

        // Read in flight (PE_request high); async reset must clear everything at once.
        #2;
        rst_n = 1'b0;
        i_rd_req = 2'b00;
        #1;
        chk_all_zero("midread_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Both clients hold read requests: grants alternate 0,1,0,1 starting at client 0.
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 6; k++) begin
                step(2'b11, 2'b00, 1'b0, (k == 4) ? 16'hC000 + 16'(n) : D);
                chk($sformatf("cont%0d.%0d rd_ack", n, k), W'(o_rd_ack),
                    (k == 0) ? W'(2'b01 << (n % 2)) : W'(0));
                if (k == 1) begin
                    chk($sformatf("cont%0d PE_request", n), W'(o_PE_request), W'(1));
                end
                if (k == 5) begin
                    chk($sformatf("cont%0d rd_valid", n), W'(o_rd_valid), W'(2'b01 << (n % 2)));
                    chk($sformatf("cont%0d rd_data", n), o_rd_data, W'(16'hC000 + 16'(n)));
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_client_arbiter.md
# sram_client_arbiter

Shares the single request/send port of the T-sequence SRAM controller between `NUM_CLIENT` DataProcessor clients. Arbitrates reads and writes round-robin and tracks the controller's fixed read latency. Routes each returned word to the client that issued the read, and blocks all traffic while the controller reports busy (T load or init).

## Interface
- `NUM_CLIENT`, default 2: number of requesting clients; 2 to 8 supported.
- `READ_LAT`, default 3: cycles from `o_PE_request` high to the cycle `i_request_data` carries the word.
- `WORD`, default `` `Sram_Word `` (256): data width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_rd_req` in NUM_CLIENT: per-client read request; level, held until `o_rd_ack`.
- `o_rd_ack` out NUM_CLIENT: one-hot, combinational, one-cycle grant of a read.
- `o_rd_valid` out NUM_CLIENT: one-hot, registered; `o_rd_data` is valid for that client this cycle.
- `o_rd_drop` out NUM_CLIENT: one-hot, registered; the granted read was discarded because busy rose.
- `o_rd_data` out WORD: returned word, shared bus, 0 when no valid.
- `i_wr_req` in NUM_CLIENT: per-client write request; level, held until `o_wr_ack`.
- `i_wr_data` in NUM_CLIENT*WORD: client k's data at bits [k*WORD +: WORD].
- `o_wr_ack` out NUM_CLIENT: one-hot, combinational, one-cycle grant of a write.
- `o_PE_request` out 1: registered read strobe to the controller.
- `i_request_data` in WORD: controller read data.
- `o_PE_send` out 1: registered write strobe to the controller.
- `o_send_data` out WORD: registered write data.
- `i_busy` in 1: controller busy.

## Operation
- States:
  - IDLE: grants allowed.
  - RD_WAIT: one read outstanding, latency counter running.
  - RD_RET: return cycle.
- Grant condition: in IDLE with `i_busy` low, at most one grant per cycle. Writes have priority over reads.
- Write grant:
  - Round-robin over `i_wr_req` using write pointer `wp`.
  - Winner k gets `o_wr_ack[k]`; `i_wr_data[k]` is registered to `o_send_data`; `o_PE_send`=1 next cycle.
  - `wp` becomes k+1 mod NUM_CLIENT.
  - State stays IDLE.
- Read grant:
  - Only when no `i_wr_req` bit is set. Round-robin over `i_rd_req` using read pointer `rp`.
  - Winner k gets `o_rd_ack[k]`, `o_PE_request`=1 next cycle for exactly one cycle, owner register := k, `rp` := k+1 mod NUM_CLIENT.
  - Go to RD_WAIT with counter := READ_LAT.
- RD_WAIT:
  - No grants of any kind; the controller port is reserved until data is captured.
  - Counter decrements each cycle. At 0, capture `i_request_data` into `o_rd_data` and go to RD_RET.
  - Capture occurs exactly READ_LAT cycles after the `o_PE_request` cycle.
- RD_RET:
  - `o_rd_valid[owner]`=1 with the captured data.
  - No grant this cycle (this honours the controller's 4-cycle request spacing).
  - Next state is IDLE.
- Busy:
  - `i_busy` high in IDLE: no acks, strobes 0.
  - `i_busy` high in RD_WAIT: drop the read, pulse `o_rd_drop[owner]` next cycle, go to IDLE. The client must re-request.
- Read order is global: the controller's read pointer advances per read regardless of client.
- Reset:
  - All outputs 0.
  - State IDLE.
  - `wp`=`rp`=0.
  - Counter 0.
  - Owner 0.
  - Reset mid-read discards the read silently.

## Timing
- Write: ack at cycle t; `o_PE_send`/`o_send_data` at t+1. Back-to-back writes run one per cycle.
- Read: ack at t; `o_PE_request` at t+1; data captured at end of t+1+READ_LAT; `o_rd_valid` at t+2+READ_LAT.
- Next grant of any kind: earliest t+3+READ_LAT.
- Combinational paths: only `i_*_req` and `i_busy` to `o_*_ack`. No combinational path from inputs to the controller-side outputs.

## Structure
- Shared package/header (`util.v`) holds:
  - `` `Sram_Word ``.
  - Arbiter state encodings ARB_IDLE/ARB_RD_WAIT/ARB_RD_RET.
  - Default READ_LAT macro `` `Sram_Read_Lat ``.
- Sub-module `rr_arbiter` (parameter N; inputs req[N], ptr, en; outputs one-hot gnt[N], gnt_idx) is instantiated twice: one for writes, one for reads.

## Test plan
- Single write: client 1 `i_wr_req`, data 0xA5… → `o_wr_ack`=2'b10 at t; `o_PE_send`=1 and `o_send_data`=0xA5… at t+1 only.
- Single read: client 0 req at t, READ_LAT=3, controller model returns 0x1234 at t+4 → `o_rd_valid`=2'b01 with `o_rd_data`=0x1234 at t+5; next ack no earlier than t+6.
- Contention: both clients hold `i_rd_req` from reset → grants alternate 0,1,0,1, with valid routed to the matching client each time.
- Write priority: client 0 read and client 1 write both raised at t → `o_wr_ack`=2'b10 at t; read ack at t+1.
- Busy abort: `i_busy` raised at t+2 after a read ack at t → `o_rd_drop`=2'b01 at t+3, no `o_rd_valid`, state IDLE; no acks while busy stays high.
- Async reset asserted during RD_WAIT → all outputs 0 immediately; after release, the first read grant goes to client 0.
